// File: rtl/pc_redirect_sequencer.sv
// -----------------------------------------------------------------------------
// pc_redirect_sequencer
//
// Purpose:
//   Owns the fetch-stage PC register of an RV32I 5-stage pipeline and picks
//   the next PC. The choices are PC+4, the branch/JAL target from the
//   EX-stage target adder, or the JALR result from the EX-stage ALU.
//   It arbitrates between a hazard-unit stall and an EX-stage redirect, and
//   it issues flushD/flushE when a redirect is taken. After reset it holds a
//   one-cycle fetch bubble. It also counts accepted redirects in a
//   saturating counter for performance monitoring.
//
// Optional feature (macro PC_MISALIGN_TRAP_EN):
//   defined   - a redirect whose target has bits [1:0] != 0 loads TRAP_VEC
//               instead of the target. misalignF pulses for one cycle,
//               together with the PCF update.
//   undefined - target bits [1:0] are forced to 00 before the load, and
//               misalignF is tied to 0.
//
// Ports:
//   clk          in   1      rising-edge clock
//   reset        in   1      synchronous, active-high reset
//   stallF       in   1      hazard unit: hold PCF
//   pcSrcE       in   2      00 seq, 01 PCTargetE, 10 ALUResultE, 11 seq
//   PCTargetE    in   32     branch/JAL target
//   ALUResultE   in   32     JALR target
//   PCF          out  32     current fetch PC (registered)
//   PCPlus4F     out  32     PCF + 4, modulo 2^32
//   fetchValidF  out  1      instruction at PCF is to be issued
//   flushD       out  1      squash IF/ID register
//   flushE       out  1      squash ID/EX register
//   redirectCnt  out  CNT_W  accepted redirects, saturating
//   misalignF    out  1      misaligned-redirect trap pulse
// -----------------------------------------------------------------------------
module pc_redirect_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stallF,
    input  logic [1:0]       pcSrcE,
    input  logic [31:0]      PCTargetE,
    input  logic [31:0]      ALUResultE,
    output logic [31:0]      PCF,
    output logic [31:0]      PCPlus4F,
    output logic             fetchValidF,
    output logic             flushD,
    output logic             flushE,
    output logic [CNT_W-1:0] redirectCnt,
    output logic             misalignF
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_REDIR = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_cnt;
    logic             w_active;
    logic             w_redirect;
    logic [31:0]      w_target;
    logic [31:0]      w_redir_pc;
    logic [31:0]      w_next_pc;

    // While reset is high, nothing is active. An in-flight redirect is
    // dropped and causes no flush.
    assign w_active   = !reset && (r_state != ST_BOOT);
    assign w_redirect = w_active && ((pcSrcE == 2'b01) || (pcSrcE == 2'b10));
    assign w_target   = (pcSrcE == 2'b01) ? PCTargetE : ALUResultE;

`ifdef PC_MISALIGN_TRAP_EN
    logic w_misaligned;
    logic r_misalign;

    assign w_misaligned = (w_target[1:0] != 2'b00);
    assign w_redir_pc   = w_misaligned ? TRAP_VEC : w_target;

    // The pulse is registered so that it lines up with the PCF load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= w_redirect && w_misaligned;
        end
    end

    assign misalignF = r_misalign;
`else
    logic w_unused_trap;

    assign w_redir_pc    = {w_target[31:2], 2'b00};
    assign w_unused_trap = ^{TRAP_VEC, w_target[1:0]};
    assign misalignF     = 1'b0;
`endif

    // A redirect beats a stall. BOOT holds the reset vector for one cycle.
    always_comb begin
        w_next_pc = r_pc;
        if (w_redirect) begin
            w_next_pc = w_redir_pc;
        end else if (r_state != ST_BOOT && !stallF) begin
            w_next_pc = r_pc + 32'd4;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = ST_BOOT;
        case (r_state)
            ST_BOOT:  w_next_state = ST_RUN;
            ST_RUN,
            ST_REDIR: w_next_state = w_redirect ? ST_REDIR : ST_RUN;
            default:  w_next_state = ST_BOOT;
        endcase
    end

    // Output logic.
    always_comb begin
        fetchValidF = w_active;
        flushD      = w_redirect;
        flushE      = w_redirect;
    end

    // PC register and saturating redirect counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc  <= RESET_VEC;
            r_cnt <= '0;
        end else begin
            r_pc <= w_next_pc;
            if (w_redirect && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign PCF         = r_pc;
    assign PCPlus4F    = r_pc + 32'd4;
    assign redirectCnt = r_cnt;

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
module tb_pc_redirect_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stallF = 1'b0;
    logic [1:0]  pcSrcE = 2'b00;
    logic [31:0] PCTargetE = 32'h0;
    logic [31:0] ALUResultE = 32'h0;

    logic [31:0] a_PCF, a_P4, b_PCF, b_P4;
    logic        a_fv, a_fd, a_fe, a_mis, b_fv, b_fd, b_fe, b_mis;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_redirect_sequencer #(.RESET_VEC(RV), .TRAP_VEC(TV), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .stallF(stallF), .pcSrcE(pcSrcE),
        .PCTargetE(PCTargetE), .ALUResultE(ALUResultE),
        .PCF(a_PCF), .PCPlus4F(a_P4), .fetchValidF(a_fv), .flushD(a_fd),
        .flushE(a_fe), .redirectCnt(a_cnt), .misalignF(a_mis));

    pc_redirect_sequencer #(.RESET_VEC(RV), .TRAP_VEC(TV), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .stallF(stallF), .pcSrcE(pcSrcE),
        .PCTargetE(PCTargetE), .ALUResultE(ALUResultE),
        .PCF(b_PCF), .PCPlus4F(b_P4), .fetchValidF(b_fv), .flushD(b_fd),
        .flushE(b_fe), .redirectCnt(b_cnt), .misalignF(b_mis));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Spec-level model: the pipeline PC, a boot-bubble flag, an unbounded
    // redirect count (clamped at compare time), and the trap pulse.
    logic [31:0] m_pc = 32'h0;
    bit          m_boot = 1'b1;
    bit          m_mis = 1'b0;
    bit          m_known = 1'b0;
    int          m_cnt = 0;

    always @(negedge clk) begin
        logic [31:0] tgt;
        bit act, red;
        act = !reset && !m_boot;
        red = act && (pcSrcE == 2'd1 || pcSrcE == 2'd2);
        if (m_known) begin
            chk("m_PCF", a_PCF, m_pc);
            chk("m_PCPlus4F", a_P4, m_pc + 32'd4);
            chk("m_fetchValidF", {31'b0, a_fv}, {31'b0, act});
            chk("m_flushD", {31'b0, a_fd}, {31'b0, red});
            chk("m_flushE", {31'b0, a_fe}, {31'b0, red});
            chk("m_cnt16", {16'b0, a_cnt}, (m_cnt > 65535) ? 32'd65535 : m_cnt);
            chk("m_misalignF", {31'b0, a_mis}, {31'b0, m_mis});
            chk("m_b_PCF", b_PCF, m_pc);
            chk("m_b_PCPlus4F", b_P4, m_pc + 32'd4);
            chk("m_b_fetchValidF", {31'b0, b_fv}, {31'b0, act});
            chk("m_b_flush", {30'b0, b_fd, b_fe}, {30'b0, red, red});
            chk("m_cnt2", {30'b0, b_cnt}, (m_cnt > 3) ? 32'd3 : m_cnt);
            chk("m_b_misalignF", {31'b0, b_mis}, {31'b0, m_mis});
        end
        tgt = (pcSrcE == 2'd1) ? PCTargetE : ALUResultE;
        if (reset) begin
            m_known = 1'b1;
            m_pc = RV; m_boot = 1'b1; m_cnt = 0; m_mis = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0; m_mis = 1'b0;
        end else if (red) begin
            m_cnt = m_cnt + 1;
`ifdef PC_MISALIGN_TRAP_EN
            m_mis = (tgt % 4) != 0;
            m_pc  = m_mis ? TV : tgt;
`else
            m_mis = 1'b0;
            m_pc  = tgt - (tgt % 4);
`endif
        end else begin
            m_mis = 1'b0;
            if (!stallF) m_pc = m_pc + 32'd4;
        end
    end

    task automatic cyc(input bit st, input logic [1:0] src, input logic [31:0] t, input logic [31:0] a);
        @(posedge clk);
        #1;
        stallF = st; pcSrcE = src; PCTargetE = t; ALUResultE = a;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("boot_pc", a_PCF, 32'h0);
        chk("boot_vld", {31'b0, a_fv}, 32'd0);
        cyc(0, 2'd0, 0, 0); chk("seq0", a_PCF, 32'h0); chk("seq0_vld", {31'b0, a_fv}, 32'd1);
        cyc(0, 2'd0, 0, 0); chk("seq4", a_PCF, 32'h4);
        cyc(0, 2'd0, 0, 0); chk("seq8", a_PCF, 32'h8);
        cyc(0, 2'd0, 0, 0); chk("seqC", a_PCF, 32'hC);
        cyc(0, 2'd1, 32'h40, 0);
        chk("br_pc", a_PCF, 32'h10);
        chk("br_flushD", {31'b0, a_fd}, 32'd1);
        chk("br_flushE", {31'b0, a_fe}, 32'd1);
        cyc(0, 2'd0, 0, 0);
        chk("br_tgt", a_PCF, 32'h40); chk("br_cnt", {16'b0, a_cnt}, 32'd1);
        chk("br_noflush", {31'b0, a_fd}, 32'd0);
        cyc(0, 2'd1, 32'h20, 0); chk("after_br", a_PCF, 32'h44);
        cyc(1, 2'd0, 0, 0); chk("stall1", a_PCF, 32'h20);
        cyc(1, 2'd0, 0, 0); chk("stall2", a_PCF, 32'h20);
        cyc(1, 2'd2, 0, 32'h80);
        chk("stall3", a_PCF, 32'h20); chk("stall3_flushE", {31'b0, a_fe}, 32'd1);
        cyc(0, 2'd1, 32'h100, 0); chk("jalr", a_PCF, 32'h80); chk("jalr_cnt", {16'b0, a_cnt}, 32'd3);
        cyc(0, 2'd2, 0, 32'h200); chk("b2b1", a_PCF, 32'h100); chk("b2b1_cnt", {16'b0, a_cnt}, 32'd4);
        cyc(0, 2'd3, 32'h555, 32'h666);
        chk("b2b2", a_PCF, 32'h200); chk("b2b2_cnt", {16'b0, a_cnt}, 32'd5);
        chk("sat_cnt2", {30'b0, b_cnt}, 32'd3);
        chk("rsvd_noflush", {31'b0, a_fd}, 32'd0);
        cyc(0, 2'd1, 32'hFFFF_FFF8, 0); chk("rsvd_seq", a_PCF, 32'h204);
        cyc(0, 2'd0, 0, 0); chk("hi_pc", a_PCF, 32'hFFFF_FFF8);
        cyc(0, 2'd0, 0, 0); chk("top_pc", a_PCF, 32'hFFFF_FFFC); chk("wrap_p4", a_P4, 32'h0);
        cyc(0, 2'd1, 32'h42, 0); chk("wrap_pc", a_PCF, 32'h0);
        cyc(0, 2'd0, 0, 0);
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis_pc", a_PCF, 32'h100); chk("mis_pulse", {31'b0, a_mis}, 32'd1);
`else
        chk("mis_pc", a_PCF, 32'h40); chk("mis_pulse", {31'b0, a_mis}, 32'd0);
`endif
        chk("mis_cnt", {16'b0, a_cnt}, 32'd7);
        cyc(0, 2'd0, 0, 0); chk("mis_end", {31'b0, a_mis}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1; pcSrcE = 2'd1; PCTargetE = 32'h300;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0; pcSrcE = 2'd0;
        @(negedge clk);
        chk("rst_pc", a_PCF, 32'h0); chk("rst_cnt", {16'b0, a_cnt}, 32'd0);
        chk("rst_vld", {31'b0, a_fv}, 32'd0);
        cyc(0, 2'd0, 0, 0); chk("rst_run0", a_PCF, 32'h0);
        cyc(0, 2'd0, 0, 0); chk("rst_run4", a_PCF, 32'h4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
